// File: rtl/axi_stream_extract_header_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_pkg
//  Description : Shared types and byte-mask helpers for the AXI-Stream header
//                insert/extract stages.
//                - xh_state_e    : extract-stage FSM state encoding
//                - keep_from_len : right-aligned byte-enable mask of len bytes
//                - keep_left     : left-aligned byte-enable mask of len bytes
//                                  inside a beat of nbytes bytes
//                - byte_count    : number of set byte enables
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_pkg;

    // Widest beat (in bytes) the mask helpers can describe; callers cast the
    // result down to their own DATA_BYTE_WD.
    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } xh_state_e;

    function automatic logic [MAX_BYTES-1:0] keep_from_len(input int len);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Byte enables are MSB-first: bit nbytes-1 is the first byte on the wire,
    // so a left-aligned mask occupies the top len bits of the beat.
    function automatic logic [MAX_BYTES-1:0] keep_left(input int len, input int nbytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < nbytes) && (i >= nbytes - len)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int byte_count(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_byte_shifter
//  Description : Combinational byte re-packer. Treats {residual_i, data_i} as
//                one MSB-first byte stream and slides it by shift_i bytes.
//  Ports       : residual_i  left-aligned bytes carried from the previous beat
//                data_i      current beat (invalid bytes already zeroed)
//                shift_i     byte offset S (0..DATA_BYTE_WD)
//                merged_o    {residual top W-S bytes, first S bytes of data_i}
//                tail_o      last W-S bytes of data_i, left-aligned
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_byte_shifter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0] residual_i,
    input  logic [DATA_WD-1:0] data_i,
    input  logic [LEN_WD-1:0]  shift_i,
    output logic [DATA_WD-1:0] merged_o,
    output logic [DATA_WD-1:0] tail_o
);

    always_comb begin
        // A shift by the full width yields zero, which covers S==0 (no bytes
        // borrowed from data_i) and S==W (empty tail) without special cases.
        merged_o = residual_i | (data_i >> (8 * (DATA_BYTE_WD - int'(shift_i))));
        tail_o   = data_i << (8 * int'(shift_i));
    end

endmodule
`default_nettype wire

// File: rtl/axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_extract_header
//  Description : Strips the first H bytes of every AXI-Stream packet onto a
//                separate header port and re-packs the remaining payload so
//                that every payload beat is full except the last.
//  Ports       : clk, rst                         clock, sync active-high reset
//                valid_len/hdr_len/ready_len      per-packet header length H
//                valid_in/data_in/keep_in/
//                last_in/ready_in                 input stream
//                valid_header/header_out/
//                keep_header/ready_header         header, right-aligned
//                valid_out/data_out/keep_out/
//                last_out/ready_out               payload stream, left-aligned
//                runt_err                         1-cycle pulse: packet <= H bytes
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_extract_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    valid_len,
    input  logic [LEN_WD-1:0]       hdr_len,
    output logic                    ready_len,

    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,

    output logic                    valid_header,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,

    output logic                    runt_err
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    xh_state_e                 state_q,      state_d;
    logic [LEN_WD-1:0]         hlen_q,       hlen_d;
    logic [DATA_WD-1:0]        resid_q,      resid_d;
    logic [LEN_WD-1:0]         rlen_q,       rlen_d;
    logic                      ready_len_q,  ready_len_d;

    logic                      valid_out_q,  valid_out_d;
    logic [DATA_WD-1:0]        data_out_q,   data_out_d;
    logic [DATA_BYTE_WD-1:0]   keep_out_q,   keep_out_d;
    logic                      last_out_q,   last_out_d;

    logic                      valid_hdr_q,  valid_hdr_d;
    logic [DATA_WD-1:0]        header_q,     header_d;
    logic [DATA_BYTE_WD-1:0]   keep_hdr_q,   keep_hdr_d;

    logic                      runt_q,       runt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                      w_out_free;
    logic                      w_hdr_free;
    logic                      w_ready_in;
    logic                      w_in_fire;
    logic [LEN_WD-1:0]         w_hlen_sat;
    logic [DATA_WD-1:0]        w_data_m;
    logic [DATA_WD-1:0]        w_merged;
    logic [DATA_WD-1:0]        w_tail;
    logic [DATA_WD-1:0]        w_hdr_data;
    int                        w_k;
    int                        w_h;
    int                        w_n;

    // Zero the bytes outside keep_in so a short last beat never leaks stale
    // bytes into the merged payload or the header.
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep_mask
            assign w_data_m[8*gi +: 8] = data_in[8*gi +: 8] & {8{keep_in[gi]}};
        end
    endgenerate

    axi_stream_byte_shifter #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .LEN_WD       (LEN_WD)
    ) u_shifter (
        .residual_i (resid_q),
        .data_i     (w_data_m),
        .shift_i    (hlen_q),
        .merged_o   (w_merged),
        .tail_o     (w_tail)
    );

    assign w_out_free = !valid_out_q || ready_out;
    assign w_hdr_free = !valid_hdr_q || ready_header;
    assign w_ready_in = ((state_q == HDR) || (state_q == BODY)) && w_out_free &&
                        ((state_q != HDR) || w_hdr_free);
    assign w_in_fire  = valid_in && w_ready_in;

    // Out-of-range lengths clamp to a whole-beat header.
    assign w_hlen_sat = (int'(hdr_len) > DATA_BYTE_WD) ? LEN_WD'(DATA_BYTE_WD) : hdr_len;

    assign w_k = byte_count(MAX_BYTES'(keep_in));
    assign w_h = int'(hlen_q);
    // A runt first beat carries fewer than H bytes; the header then holds
    // only what arrived.
    assign w_n = (w_k < w_h) ? w_k : w_h;
    assign w_hdr_data = w_data_m >> (8 * (DATA_BYTE_WD - w_n));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hlen_d      = hlen_q;
        resid_d     = resid_q;
        rlen_d      = rlen_q;

        valid_out_d = valid_out_q && !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;

        valid_hdr_d = valid_hdr_q && !ready_header;
        header_d    = header_q;
        keep_hdr_d  = keep_hdr_q;

        runt_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_len && ready_len_q) begin
                    hlen_d  = w_hlen_sat;
                    state_d = HDR;
                end
            end

            HDR: begin
                if (w_in_fire) begin
                    if (w_h != 0) begin
                        valid_hdr_d = 1'b1;
                        header_d    = w_hdr_data;
                        keep_hdr_d  = DATA_BYTE_WD'(keep_from_len(w_n));
                    end
                    resid_d = w_tail;
                    if (last_in) begin
                        state_d = IDLE;
                        if (w_k <= w_h) begin
                            runt_d = 1'b1;
                        end else begin
                            // Single-beat packet longer than the header: the
                            // leftover bytes form the whole payload.
                            valid_out_d = 1'b1;
                            data_out_d  = w_tail;
                            keep_out_d  = DATA_BYTE_WD'(keep_left(w_k - w_h, DATA_BYTE_WD));
                            last_out_d  = 1'b1;
                        end
                    end else begin
                        state_d = BODY;
                    end
                end
            end

            BODY: begin
                if (w_in_fire) begin
                    valid_out_d = 1'b1;
                    data_out_d  = w_merged;
                    if (last_in && (w_k <= w_h)) begin
                        keep_out_d = DATA_BYTE_WD'(keep_left(DATA_BYTE_WD - w_h + w_k, DATA_BYTE_WD));
                        last_out_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        resid_d    = w_tail;
                        if (last_in) begin
                            // The tail still holds k-H bytes that need a beat
                            // of their own.
                            rlen_d  = LEN_WD'(w_k - w_h);
                            state_d = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                if (w_out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = resid_q;
                    keep_out_d  = DATA_BYTE_WD'(keep_left(int'(rlen_q), DATA_BYTE_WD));
                    last_out_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_len_d = (state_d == IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hlen_q      <= '0;
            resid_q     <= '0;
            rlen_q      <= '0;
            ready_len_q <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            valid_hdr_q <= 1'b0;
            header_q    <= '0;
            keep_hdr_q  <= '0;
            runt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hlen_q      <= hlen_d;
            resid_q     <= resid_d;
            rlen_q      <= rlen_d;
            ready_len_q <= ready_len_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            valid_hdr_q <= valid_hdr_d;
            header_q    <= header_d;
            keep_hdr_q  <= keep_hdr_d;
            runt_q      <= runt_d;
        end
    end

    assign ready_len    = ready_len_q;
    assign ready_in     = w_ready_in;
    assign valid_header = valid_hdr_q;
    assign header_out   = header_q;
    assign keep_header  = keep_hdr_q;
    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign keep_out     = keep_out_q;
    assign last_out     = last_out_q;
    assign runt_err     = runt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_extract_header.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_extract_header
//  Description : Directed self-checking bench for axi_stream_extract_header
//                with DATA_WD=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_extract_header;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_len;
    logic [2:0]  hdr_len;
    logic        ready_len;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_header;
    logic [31:0] header_out;
    logic [3:0]  keep_header;
    logic        ready_header;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        runt_err;

    int n_assert = 0;
    int n_fail   = 0;

    beat_t out_q[$];
    beat_t hdr_q[$];
    int    rd_out = 0;
    int    rd_hdr = 0;
    int    runt_cnt = 0;
    int    hold_checks = 0;
    int    hold_viol = 0;

    always #5 clk = ~clk;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_len    (valid_len),
        .hdr_len      (hdr_len),
        .ready_len    (ready_len),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_header (valid_header),
        .header_out   (header_out),
        .keep_header  (keep_header),
        .ready_header (ready_header),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .runt_err     (runt_err)
    );

    // Monitor: records transfers and watches held outputs for stability.
    logic        p_hold_o = 1'b0;
    logic        p_hold_h = 1'b0;
    beat_t       p_out;
    beat_t       p_hdr;
    always @(negedge clk) begin
        if (rst) begin
            p_hold_o = 1'b0;
            p_hold_h = 1'b0;
        end else begin
            if (p_hold_o) begin
                hold_checks++;
                if (!(valid_out === 1'b1 && {data_out, keep_out, last_out} === p_out)) hold_viol++;
            end
            if (p_hold_h) begin
                hold_checks++;
                if (!(valid_header === 1'b1 && {header_out, keep_header, 1'b0} === p_hdr)) hold_viol++;
            end
            p_hold_o = valid_out && !ready_out;
            p_out    = {data_out, keep_out, last_out};
            p_hold_h = valid_header && !ready_header;
            p_hdr    = {header_out, keep_header, 1'b0};
            if (valid_out && ready_out) out_q.push_back({data_out, keep_out, last_out});
            if (valid_header && ready_header) hdr_q.push_back({header_out, keep_header, 1'b0});
            if (runt_err) runt_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_len(input int h);
        int   cnt;
        logic ok;
        cnt = 0;
        ok  = 1'b0;
        valid_len = 1'b1;
        hdr_len   = 3'(h);
        while (!ok && cnt < 100) begin
            @(negedge clk);
            ok = ready_len;
            @(posedge clk);
            #1;
            cnt++;
        end
        valid_len = 1'b0;
        chk("len_handshake", 64'(ok), 64'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   cnt;
        logic ok;
        cnt = 0;
        ok  = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (!ok && cnt < 100) begin
            @(negedge clk);
            ok = ready_in;
            @(posedge clk);
            #1;
            cnt++;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        chk("beat_handshake", 64'(ok), 64'd1);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        if (rd_out < out_q.size()) b = out_q[rd_out];
        else b = 'x;
        rd_out++;
        chk(tag, 64'(b), 64'({d, k, l}));
    endtask

    task automatic chk_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
        beat_t b;
        if (rd_hdr < hdr_q.size()) b = hdr_q[rd_hdr];
        else b = 'x;
        rd_hdr++;
        chk(tag, 64'(b), 64'({d, k, 1'b0}));
    endtask

    function automatic int ones4(input logic [3:0] k);
        return int'(k[0]) + int'(k[1]) + int'(k[2]) + int'(k[3]);
    endfunction

    initial begin
        int r0;
        int hv0;
        int hc0;
        int bytes;
        logic to_flag;

        rst = 1'b1;
        valid_len = 1'b0; hdr_len = '0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_header = 1'b1; ready_out = 1'b1;
        tick(3);

        // Reset state
        chk("rst_ready_len",    64'(ready_len),    64'd0);
        chk("rst_ready_in",     64'(ready_in),     64'd0);
        chk("rst_valid_header", 64'(valid_header), 64'd0);
        chk("rst_valid_out",    64'(valid_out),    64'd0);
        chk("rst_last_out",     64'(last_out),     64'd0);
        chk("rst_runt_err",     64'(runt_err),     64'd0);
        chk("rst_data_keep",    64'({data_out, keep_out}),      64'd0);
        chk("rst_hdr_keep",     64'({header_out, keep_header}), 64'd0);
        rst = 1'b0;
        tick(1);

        // H=3, three beats, short last beat
        r0 = runt_cnt;
        send_len(3);
        send_beat(32'hAABBCCDD, 4'hF, 1'b0);
        send_beat(32'hEEFF0011, 4'hF, 1'b0);
        send_beat(32'h22330000, 4'hC, 1'b1);
        tick(5);
        chk_hdr("t1_hdr", 32'h00AABBCC, 4'h7);
        chk_out("t1_b0", 32'hDDEEFF00, 4'hF, 1'b0);
        chk_out("t1_b1", 32'h11223300, 4'hE, 1'b1);
        chk("t1_nout", 64'(out_q.size()), 64'(rd_out));
        chk("t1_nhdr", 64'(hdr_q.size()), 64'(rd_hdr));
        chk("t1_runt", 64'(runt_cnt - r0), 64'd0);

        // H=1, full last beat spills into FLUSH
        send_len(1);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hF, 1'b1);
        chk("t2_flush_ready_in", 64'(ready_in), 64'd0);
        tick(5);
        chk_hdr("t2_hdr", 32'h00000011, 4'h1);
        chk_out("t2_b0", 32'h22334455, 4'hF, 1'b0);
        chk_out("t2_b1", 32'h66778800, 4'hE, 1'b1);
        chk("t2_nout", 64'(out_q.size()), 64'(rd_out));

        // H=4 runt: two bytes only
        r0 = runt_cnt;
        send_len(4);
        send_beat(32'hAABB0000, 4'hC, 1'b1);
        tick(5);
        chk_hdr("t3_hdr", 32'h0000AABB, 4'h3);
        chk("t3_nout", 64'(out_q.size()), 64'(rd_out));
        chk("t3_runt", 64'(runt_cnt - r0), 64'd1);

        // hdr_len=7 saturates to 4: exact-length runt
        r0 = runt_cnt;
        send_len(7);
        send_beat(32'h12345678, 4'hF, 1'b1);
        tick(5);
        chk_hdr("t3b_hdr", 32'h12345678, 4'hF);
        chk("t3b_nout", 64'(out_q.size()), 64'(rd_out));
        chk("t3b_runt", 64'(runt_cnt - r0), 64'd1);

        // H=0 passes through, then H=4 removes the whole first beat
        send_len(0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0B0C, 4'hF, 1'b1);
        tick(5);
        chk("t4a_nhdr", 64'(hdr_q.size()), 64'(rd_hdr));
        chk_out("t4a_b0", 32'h01020304, 4'hF, 1'b0);
        chk_out("t4a_b1", 32'h05060708, 4'hF, 1'b0);
        chk_out("t4a_b2", 32'h090A0B0C, 4'hF, 1'b1);
        send_len(4);
        send_beat(32'h11121314, 4'hF, 1'b0);
        send_beat(32'h15161718, 4'hF, 1'b0);
        send_beat(32'h191A0000, 4'hC, 1'b1);
        tick(5);
        chk_hdr("t4b_hdr", 32'h11121314, 4'hF);
        chk_out("t4b_b0", 32'h15161718, 4'hF, 1'b0);
        chk_out("t4b_b1", 32'h191A0000, 4'hC, 1'b1);
        chk("t4_nout", 64'(out_q.size()), 64'(rd_out));

        // H=2, 22-byte packet with header and payload back-pressure
        hv0 = hold_viol;
        hc0 = hold_checks;
        to_flag = 1'b0;
        ready_header = 1'b0;
        fork
            begin
                send_len(2);
                for (int i = 0; i < 5; i++) begin
                    send_beat({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 4'hF, 1'b0);
                end
                send_beat(32'h14150000, 4'hC, 1'b1);
            end
            begin
                int cnt;
                cnt = 0;
                while (!valid_header && cnt < 100) begin
                    @(negedge clk);
                    cnt++;
                end
                if (cnt >= 100) to_flag = 1'b1;
                tick(2);
                ready_header = 1'b1;
                tick(1);
                ready_out = 1'b0;
                tick(3);
                ready_out = 1'b1;
            end
        join
        tick(8);
        chk("t5_ctl_timeout", 64'(to_flag), 64'd0);
        bytes = 0;
        for (int i = rd_hdr; i < hdr_q.size(); i++) bytes += ones4(hdr_q[i].k);
        for (int i = rd_out; i < out_q.size(); i++) bytes += ones4(out_q[i].k);
        chk("t5_bytes", 64'(bytes), 64'd22);
        chk_hdr("t5_hdr", 32'h00000001, 4'h3);
        chk_out("t5_b0", 32'h02030405, 4'hF, 1'b0);
        chk_out("t5_b1", 32'h06070809, 4'hF, 1'b0);
        chk_out("t5_b2", 32'h0A0B0C0D, 4'hF, 1'b0);
        chk_out("t5_b3", 32'h0E0F1011, 4'hF, 1'b0);
        chk_out("t5_b4", 32'h12131415, 4'hF, 1'b1);
        chk("t5_nout", 64'(out_q.size()), 64'(rd_out));
        chk("t5_hold_viol", 64'(hold_viol - hv0), 64'd0);
        chk("t5_hold_seen", 64'(hold_checks > hc0), 64'd1);

        // Reset in BODY drops the partial packet
        send_len(2);
        send_beat(32'hA0A1A2A3, 4'hF, 1'b0);
        send_beat(32'hA4A5A6A7, 4'hF, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("t6_valid_out",    64'(valid_out),    64'd0);
        chk("t6_valid_header", 64'(valid_header), 64'd0);
        chk("t6_ready_in",     64'(ready_in),     64'd0);
        chk("t6_last_out",     64'(last_out),     64'd0);
        rst = 1'b0;
        rd_out = out_q.size();
        rd_hdr = hdr_q.size();
        tick(1);
        send_len(3);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0000, 4'hC, 1'b1);
        tick(5);
        chk_hdr("t6_hdr", 32'h00010203, 4'h7);
        chk_out("t6_b0", 32'h04050607, 4'hF, 1'b0);
        chk_out("t6_b1", 32'h08090A00, 4'hE, 1'b1);
        chk("t6_nout", 64'(out_q.size()), 64'(rd_out));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
